// File: rtl/control_sequencer_if.sv
// Instruction-fetch handshake between the control sequencer and instruction memory.
interface control_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for an RV32 integer subset
// (R-type ALU, I-type ALU incl. shifts, LUI); any other opcode halts until reset.
module control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  control_sequencer_if.master        imem,
  output logic [6:0]                 op,
  output logic [4:0]                 addr_a,
  output logic [4:0]                 addr_b,
  output logic [4:0]                 addr_d,
  output logic [31:0]                immed,
  output logic                       y_sel,
  output logic                       write,
  output logic                       halted,
  output logic [31:0]                retired
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [6:0]  op_q, op_d;
  logic [4:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_d_q, addr_d_d;
  logic [31:0] immed_q, immed_d;
  logic        y_sel_q, y_sel_d;

  logic        dec_legal;
  logic [6:0]  dec_op;
  logic [4:0]  dec_a, dec_b, dec_d;
  logic [31:0] dec_immed;
  logic        dec_y_sel;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = '0;
    dec_a     = '0;
    dec_b     = '0;
    dec_d     = '0;
    dec_immed = '0;
    dec_y_sel = 1'b0;
    case (ir_q[6:0])
      7'b0110011: begin
        dec_y_sel = 1'b1;
        dec_a     = ir_q[19:15];
        dec_b     = ir_q[24:20];
        dec_d     = ir_q[11:7];
        dec_op    = {3'b000, ir_q[30], ir_q[14:12]};
      end
      7'b0010011: begin
        dec_a = ir_q[19:15];
        dec_d = ir_q[11:7];
        // Shifts carry the arithmetic/logical select in IR[30] and a 5-bit shamt.
        if (ir_q[14:12] == 3'b001 || ir_q[14:12] == 3'b101) begin
          dec_immed = {27'b0, ir_q[24:20]};
          dec_op    = {3'b000, ir_q[30], ir_q[14:12]};
        end else begin
          dec_immed = {{20{ir_q[31]}}, ir_q[31:20]};
          dec_op    = {4'b0000, ir_q[14:12]};
        end
      end
      7'b0110111: begin
        dec_d     = ir_q[11:7];
        dec_immed = {ir_q[31:12], 12'b0};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    op_d      = op_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    addr_d_d  = addr_d_q;
    immed_d   = immed_q;
    y_sel_d   = y_sel_q;
    case (state_q)
      FETCH: begin
        if (req_q && imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_legal) begin
          op_d     = dec_op;
          addr_a_d = dec_a;
          addr_b_d = dec_b;
          addr_d_d = dec_d;
          immed_d  = dec_immed;
          y_sel_d  = dec_y_sel;
          state_d  = EXEC;
        end else begin
          state_d = HALT;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        pc_d      = pc_q + 32'd4;
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
    // Request is registered so it stays low through reset and rises on the first edge after.
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      req_q     <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      op_q      <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_d_q  <= '0;
      immed_q   <= '0;
      y_sel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      op_q      <= op_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      addr_d_q  <= addr_d_d;
      immed_q   <= immed_d;
      y_sel_q   <= y_sel_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign op             = op_q;
  assign addr_a         = addr_a_q;
  assign addr_b         = addr_b_q;
  assign addr_d         = addr_d_q;
  assign immed          = immed_q;
  assign y_sel          = y_sel_q;
  assign write          = (state_q == WB) && (addr_d_q != 5'd0);
  assign halted         = (state_q == HALT);
  assign retired        = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, randomized legal instructions
// against a field-extraction decode model, and reset / halt / PC-wrap sequences.
module tb_control_sequencer;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n;

  control_sequencer_if ifc1 ();
  control_sequencer_if ifc2 ();

  logic [6:0]  op1, op2;
  logic [4:0]  a1, b1, d1, a2, b2, d2;
  logic [31:0] imm1, imm2, ret1, ret2;
  logic        ysel1, ysel2, wr1, wr2, halt1, halt2;

  control_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(rst_n), .imem(ifc1),
    .op(op1), .addr_a(a1), .addr_b(b1), .addr_d(d1), .immed(imm1),
    .y_sel(ysel1), .write(wr1), .halted(halt1), .retired(ret1)
  );

  control_sequencer #(.RESET_PC(RPC2)) dut_wrap (
    .clk(clk), .reset(rst2_n), .imem(ifc2),
    .op(op2), .addr_a(a2), .addr_b(b2), .addr_d(d2), .immed(imm2),
    .y_sel(ysel2), .write(wr2), .halted(halt2), .retired(ret2)
  );

  // Second instance free-runs ADDI x1,x0,1 from a PC one word below the wrap point.
  assign ifc2.imem_ack   = 1'b1;
  assign ifc2.imem_rdata = 32'h0010_0093;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  a, b, d;
    logic [31:0] imm;
    logic        ysel;
    logic        legal;
  } dec_t;

  typedef struct {
    logic [31:0] ir;
    int unsigned delay;
    dec_t        e;
    logic        wr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode model from instruction field arithmetic.
  function automatic dec_t model(input logic [31:0] ir);
    dec_t m;
    int unsigned opc, f3, rd, rs1, rs2, b30;
    opc = ir % 128;
    f3  = (ir / 4096) % 8;
    rd  = (ir / 128) % 32;
    rs1 = (ir / 32768) % 32;
    rs2 = (ir / 1048576) % 32;
    b30 = (ir / 1073741824) % 2;
    m = '{op: '0, a: '0, b: '0, d: '0, imm: '0, ysel: 1'b0, legal: 1'b1};
    if (opc == 51) begin
      m.ysel = 1'b1;
      m.a    = 5'(rs1);
      m.b    = 5'(rs2);
      m.d    = 5'(rd);
      m.op   = 7'(b30 * 8 + f3);
    end else if (opc == 19) begin
      m.a = 5'(rs1);
      m.d = 5'(rd);
      if (f3 == 1 || f3 == 5) begin
        m.imm = 32'(rs2);
        m.op  = 7'(b30 * 8 + f3);
      end else begin
        m.imm = $signed(ir) >>> 20;
        m.op  = 7'(f3);
      end
    end else if (opc == 55) begin
      m.d   = 5'(rd);
      m.imm = ir - (ir % 4096);
    end else begin
      m.legal = 1'b0;
    end
    return m;
  endfunction

  task automatic chk_fields(input string tag, input dec_t e);
    chk({tag, "_op"},   32'(op1),   32'(e.op));
    chk({tag, "_a"},    32'(a1),    32'(e.a));
    chk({tag, "_b"},    32'(b1),    32'(e.b));
    chk({tag, "_d"},    32'(d1),    32'(e.d));
    chk({tag, "_imm"},  imm1,       e.imm);
    chk({tag, "_ysel"}, 32'(ysel1), 32'(e.ysel));
  endtask

  task automatic run_instr(input logic [31:0] ir, input int unsigned delay,
                           input dec_t e, input logic exp_wr);
    chk("fetch_req", 32'(ifc1.imem_req), 32'd1);
    chk("fetch_addr", ifc1.imem_addr, exp_pc);
    for (int unsigned i = 0; i < delay; i++) begin
      ifc1.imem_ack   = 1'b0;
      ifc1.imem_rdata = $urandom;
      step();
      chk("wait_req", 32'(ifc1.imem_req), 32'd1);
      chk("wait_addr", ifc1.imem_addr, exp_pc);
    end
    ifc1.imem_ack   = 1'b1;
    ifc1.imem_rdata = ir;
    step();
    ifc1.imem_ack   = 1'($urandom_range(0, 1));
    ifc1.imem_rdata = $urandom;
    chk("decode_write", 32'(wr1), 32'd0);
    chk("decode_req", 32'(ifc1.imem_req), 32'd0);
    if (!e.legal) begin
      step();
      chk("halt_flag", 32'(halt1), 32'd1);
      for (int unsigned i = 0; i < 20; i++) begin
        ifc1.imem_ack = 1'($urandom_range(0, 1));
        step();
        chk("halt_write", 32'(wr1), 32'd0);
        chk("halt_req", 32'(ifc1.imem_req), 32'd0);
        chk("halt_hold", 32'(halt1), 32'd1);
        chk("halt_retired", ret1, exp_ret);
      end
      return;
    end
    step();
    ifc1.imem_ack = 1'($urandom_range(0, 1));
    chk_fields("exec", e);
    chk("exec_write", 32'(wr1), 32'd0);
    step();
    ifc1.imem_ack = 1'b0;
    chk_fields("wb", e);
    chk("wb_write", 32'(wr1), 32'(exp_wr));
    chk("wb_halted", 32'(halt1), 32'd0);
    step();
    exp_pc  = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    chk("next_write", 32'(wr1), 32'd0);
    chk("retired", ret1, exp_ret);
    chk("next_addr", ifc1.imem_addr, exp_pc);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(ifc1.imem_req), 32'd0);
    chk("rst_halted", 32'(halt1), 32'd0);
    chk("rst_addr", ifc1.imem_addr, RPC);
    chk("rst_retired", ret1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_pc  = RPC;
    exp_ret = '0;
    chk("post_rst_req", 32'(ifc1.imem_req), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{ir: 32'h0020_81B3, delay: 0, wr: 1'b1,
                e: '{op: 7'h00, a: 5'd1, b: 5'd2, d: 5'd3, imm: 32'h0, ysel: 1'b1, legal: 1'b1}};
    vecs[1] = '{ir: 32'hFFF0_0293, delay: 1, wr: 1'b1,
                e: '{op: 7'h00, a: 5'd0, b: 5'd0, d: 5'd5, imm: 32'hFFFF_FFFF, ysel: 1'b0, legal: 1'b1}};
    vecs[2] = '{ir: 32'h4043_5313, delay: 2, wr: 1'b1,
                e: '{op: 7'h0D, a: 5'd6, b: 5'd0, d: 5'd6, imm: 32'h4, ysel: 1'b0, legal: 1'b1}};
    vecs[3] = '{ir: 32'h1234_53B7, delay: 0, wr: 1'b1,
                e: '{op: 7'h00, a: 5'd0, b: 5'd0, d: 5'd7, imm: 32'h1234_5000, ysel: 1'b0, legal: 1'b1}};
    vecs[4] = '{ir: 32'h0000_0013, delay: 3, wr: 1'b0,
                e: '{op: 7'h00, a: 5'd0, b: 5'd0, d: 5'd0, imm: 32'h0, ysel: 1'b0, legal: 1'b1}};

    rst_n = 1'b0;
    rst2_n = 1'b0;
    ifc1.imem_ack = 1'b0;
    ifc1.imem_rdata = '0;
    exp_pc = RPC;
    exp_ret = '0;

    #12;
    chk("reset_op", 32'(op1), 32'd0);
    chk("reset_a", 32'(a1), 32'd0);
    chk("reset_b", 32'(b1), 32'd0);
    chk("reset_d", 32'(d1), 32'd0);
    chk("reset_imm", imm1, 32'd0);
    chk("reset_ysel", 32'(ysel1), 32'd0);
    chk("reset_write", 32'(wr1), 32'd0);
    chk("reset_halted", 32'(halt1), 32'd0);
    chk("reset_req", 32'(ifc1.imem_req), 32'd0);
    chk("reset_retired", ret1, 32'd0);
    chk("reset_addr", ifc1.imem_addr, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_req_low", 32'(ifc1.imem_req), 32'd0);
    step();
    chk("first_edge_req", 32'(ifc1.imem_req), 32'd1);

    foreach (vecs[i]) run_instr(vecs[i].ir, vecs[i].delay, vecs[i].e, vecs[i].wr);

    // Illegal instruction halts until reset.
    run_instr(32'h0000_0000, 0, model(32'h0000_0000), 1'b0);
    reset_pulse();

    for (int i = 0; i < 120; i++) begin
      logic [31:0] ir;
      dec_t        e;
      ir = $urandom;
      case ($urandom_range(0, 3))
        0: ir = (ir & ~32'h7F) | 32'h33;
        1, 2: ir = (ir & ~32'h7F) | 32'h13;
        default: ir = (ir & ~32'h7F) | 32'h37;
      endcase
      if ($urandom_range(0, 7) == 0) ir = ir & ~32'h0000_0F80;
      e = model(ir);
      run_instr(ir, $urandom_range(0, 3), e, e.d != 5'd0);
    end

    // Reset while a fetch is pending drops the request without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfetch_req", 32'(ifc1.imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_pc = RPC;
    exp_ret = '0;

    // Reset during write-back: write drops immediately and nothing retires.
    run_instr(32'h0020_81B3, 0, model(32'h0020_81B3), 1'b1);
    ifc1.imem_ack = 1'b1;
    ifc1.imem_rdata = 32'h0020_81B3;
    step();
    ifc1.imem_ack = 1'b0;
    step();
    step();
    chk("midwb_write_before", 32'(wr1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwb_write", 32'(wr1), 32'd0);
    chk("midwb_req", 32'(ifc1.imem_req), 32'd0);
    chk("midwb_retired", ret1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("after_wb_rst_retired", ret1, 32'd0);
      chk("after_wb_rst_addr", ifc1.imem_addr, RPC);
    end

    // PC wrap on the second instance.
    @(negedge clk);
    rst2_n = 1'b1;
    step();
    chk("wrap_req", 32'(ifc2.imem_req), 32'd1);
    chk("wrap_addr0", ifc2.imem_addr, RPC2);
    step();
    step();
    step();
    chk("wrap_write", 32'(wr2), 32'd1);
    step();
    chk("wrap_addr", ifc2.imem_addr, 32'h0000_0000);
    chk("wrap_retired", ret2, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
